// File: rtl/ifu_bpu.sv
// ifu_bpu: static branch predictor for JAL/JALR/Bxx with JALR rs1 hazard resolution.
// Optional macro SIMPLECORE_BPU_JALR_XN_EN enables resolving xn JALR through a read port 1 borrow.
module ifu_bpu #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [PC_SIZE-1:0]     i_pc,
  input  logic                   dec_bjp,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  input  logic                   oitf_empty,
  input  logic                   ir_empty,
  input  logic                   ir_rs1en,
  input  logic                   ir_rden,
  input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
  input  logic                   flush_req,
  output logic                   bpu_wait,
  output logic                   prdt_valid,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc,
  output logic                   bpu2rf_rs1_ena,
  output logic [RFIDX_WIDTH-1:0] bpu2rf_rs1_idx
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_X1, S_WAIT_XN, S_RF_REQ, S_RF_RD} state_t;
  state_t state, state_nxt;
  logic bjp_v, rs1_x0, rs1_x1, ir_wr, dep_x1, jalr_xn, xn_fall, live, fire, wait_c, taken_c, jalr_tgt;
  logic [XLEN-1:0] base, op1, op2, sum, tgt;
  assign bjp_v   = i_valid & dec_bjp;
  assign rs1_x0  = dec_jalr_rs1idx == '0;
  assign rs1_x1  = dec_jalr_rs1idx == RFIDX_WIDTH'(1);
  assign ir_wr   = ~ir_empty & ir_rden;
  assign dep_x1  = ~oitf_empty | (ir_wr & (ir_rdidx == RFIDX_WIDTH'(1)));
  assign jalr_xn = dec_jalr & ~rs1_x0 & ~rs1_x1;
  assign live    = rst_n & ~flush_req;
`ifdef SIMPLECORE_BPU_JALR_XN_EN
  logic xn_ready;
  assign xn_fall        = 1'b0;
  assign xn_ready       = oitf_empty & ~(ir_wr & (ir_rdidx == dec_jalr_rs1idx)) & (ir_empty | ~ir_rs1en);
  assign bpu2rf_rs1_ena = live & (state == S_RF_REQ);
  assign bpu2rf_rs1_idx = dec_jalr_rs1idx;
  assign base           = (state == S_RF_RD) ? rf2bpu_rs1 : rs1_x0 ? '0 : rf2bpu_x1;
`else
  logic unused_xn;
  assign xn_fall        = jalr_xn;
  assign bpu2rf_rs1_ena = 1'b0;
  assign bpu2rf_rs1_idx = '0;
  assign base           = rs1_x0 ? '0 : rf2bpu_x1;
  assign unused_xn      = ^{rf2bpu_rs1, ir_rs1en};
`endif
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    wait_c    = 1'b0;
    case (state)
      S_IDLE: if (bjp_v) begin
        if (dec_jalr & rs1_x1 & dep_x1) begin
          wait_c    = 1'b1;
          state_nxt = S_WAIT_X1;
        end
`ifdef SIMPLECORE_BPU_JALR_XN_EN
        else if (jalr_xn) begin
          wait_c    = 1'b1;
          state_nxt = S_WAIT_XN;
        end
`endif
        else fire = 1'b1;
      end
      S_WAIT_X1: begin
        fire      = ~dep_x1;
        wait_c    = dep_x1;
        state_nxt = dep_x1 ? S_WAIT_X1 : S_IDLE;
      end
`ifdef SIMPLECORE_BPU_JALR_XN_EN
      S_WAIT_XN: begin
        wait_c    = 1'b1;
        state_nxt = xn_ready ? S_RF_REQ : S_WAIT_XN;
      end
      S_RF_REQ: begin
        wait_c    = 1'b1;
        state_nxt = S_RF_RD;
      end
      S_RF_RD: begin
        fire      = 1'b1;
        state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (flush_req) state_nxt = S_IDLE;
  end
  // JALR (except the no-wait xn fallback) adds to its base; not-taken Bxx and fallback use pc+4
  assign jalr_tgt   = dec_jalr & ~xn_fall;
  assign op1        = jalr_tgt ? base : XLEN'(i_pc);
  assign op2        = (xn_fall | (dec_bxx & ~dec_bjp_imm[XLEN-1])) ? XLEN'(4) : dec_bjp_imm;
  assign sum        = op1 + op2;
  assign tgt        = jalr_tgt ? {sum[XLEN-1:1], 1'b0} : sum;
  assign taken_c    = dec_jal | jalr_tgt | (dec_bxx & dec_bjp_imm[XLEN-1]);
  assign prdt_valid = live & fire;
  assign bpu_wait   = live & wait_c;
  assign prdt_taken = prdt_valid & taken_c;
  assign prdt_pc    = prdt_valid ? PC_SIZE'(tgt) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (rst_n && state != S_IDLE) assert (i_valid);
endmodule
